rtc_rst_sequencer: RTL and testbench
====================================

# rtc_rst_sequencer

Parametrised reset sequencer in the RTC clock domain: the next generation of the lock-delay system-reset logic in the clock unit. It synchronises the PLL `lock`, requires it to stay stable for `LOCK_DLY` RTC cycles, then releases `NUM_CH` active-low reset channels one by one at `STAGGER`-cycle spacing. It re-asserts every channel on lock loss or on a software reset request, and counts lock-loss events. It sits beside the PLL/RTC divider and drives the core, peripheral and bus reset domains.

## Interface
Parameters:
- `NUM_CH`, 3: number of reset channels, 1..16.
- `LOCK_DLY`, 8: consecutive synchronised-lock cycles required before release, ≥1.
- `STAGGER`, 4: cycles between successive channel releases, ≥1.
- `HOLD_CYC`, 16: reset hold length after a software request, ≥1.
- `CNT_W`, 8: width of the lock-loss counter.
- `TICK_DIV`, 32768: tick period in cycles, only with `RTC_RST_SEQ_TICK_EN`, ≥2.

Ports:
- `clkout_rtc  in  1`: RTC clock; all state changes on its rising edge.
- `reset  in  1`: asynchronous, active-low.
- `lock  in  1`: PLL lock, asynchronous to `clkout_rtc`.
- `sw_rst_req  in  1`: synchronous software reset request, level-sampled.
- `rst_n_out  out  NUM_CH`: active-low channel resets; bit 0 releases first.
- `all_released  out  1`: high while in RUN.
- `state  out  2`: WAIT_LOCK=0, RELEASE=1, RUN=2, HOLD=3.
- `lock_lost_cnt  out  CNT_W`: saturating lock-loss count.
- `tick  out  1`: one-cycle periodic pulse (see Configuration).

## Operation
- Reset values: `rst_n_out`=0, `all_released`=0, `state`=WAIT_LOCK, `lock_lost_cnt`=0, `tick`=0. The sync flops, `dly_cnt`, `rel_cnt`, `stg_cnt`, `hold_cnt` and the tick counter are all cleared.
- `lock` passes through a two-flop synchroniser to `lock_s`. Nothing else samples raw `lock`.
- **WAIT_LOCK:**
  - `dly_cnt` increments while `lock_s`=1 and clears when `lock_s`=0.
  - When `lock_s`=1 and `dly_cnt`==`LOCK_DLY`-1, go to RELEASE. On that same edge, `rel_cnt`=1 and `rst_n_out[0]`=1.
- **RELEASE:**
  - `stg_cnt` counts 0..`STAGGER`-1.
  - At wrap, `rel_cnt` increments and releases the next channel.
  - `rst_n_out[k]` = (k < `rel_cnt`).
  - When `rel_cnt` reaches `NUM_CH`, go to RUN on the same edge; `all_released`=1 on that edge.
  - With `NUM_CH`=1, WAIT_LOCK goes directly to RUN.
- **RUN:** outputs are held. `sw_rst_req`=1 causes the next edge to set all `rst_n_out`=0, `all_released`=0, enter HOLD and clear `hold_cnt`.
- **HOLD:**
  - After `HOLD_CYC` cycles, go to WAIT_LOCK with `dly_cnt`=0, so lock is re-qualified for the full `LOCK_DLY`.
  - `sw_rst_req` is ignored outside RUN.
- **Lock loss:** `lock_s`=0 in RELEASE, RUN or HOLD causes the next edge to:
  - set all `rst_n_out`=0 and `all_released`=0;
  - enter WAIT_LOCK with `dly_cnt`=0;
  - increment `lock_lost_cnt`, saturating at all-ones.
- Lock loss in WAIT_LOCK only clears `dly_cnt`; it is not counted.
- **Simultaneous events:** lock loss together with `sw_rst_req` in RUN → lock loss wins (WAIT_LOCK, counter increments, HOLD skipped).
- **Reset mid-operation:** `reset` low at any time asynchronously forces all reset values. Release starts over only after lock re-qualification.

## Timing
- `lock` rises and stays high: `rst_n_out[0]` rises on the (2+`LOCK_DLY`)th rising edge, counting the first edge that samples `lock`=1 as edge 1.
- `rst_n_out[k]` rises k·`STAGGER` edges after `rst_n_out[0]`.
- `all_released` rises on the same edge as `rst_n_out[NUM_CH-1]`.
- Lock loss: `rst_n_out` falls 3 edges after the first edge sampling `lock`=0 (2 sync + 1 register).
- `sw_rst_req` in RUN: `rst_n_out` falls on the next edge; WAIT_LOCK is entered `HOLD_CYC` edges later.
- `lock_lost_cnt` updates on the same edge the resets fall.
- All outputs are registered; there are no combinational paths from any input to any output.

## Configuration
- **`RTC_RST_SEQ_TICK_EN` defined:**
  - Adds a `clog2(TICK_DIV)`-bit counter, active only in RUN and cleared in every other state.
  - `tick`=1 for one cycle when the counter wraps at `TICK_DIV`-1. The first tick comes `TICK_DIV` edges after entering RUN.
- **Undefined:** the counter is absent and `tick` is tied to 0.

## Test plan
- `NUM_CH`=3, `LOCK_DLY`=8, `STAGGER`=4; raise `lock` and hold → `rst_n_out` bits 0/1/2 rise at edges 10/14/18; `all_released` and `state`=2 at edge 18.
- `lock` glitches low for 1 cycle at `dly_cnt`=5 in WAIT_LOCK → `dly_cnt` restarts; `rst_n_out[0]` is delayed by the full `LOCK_DLY`; `lock_lost_cnt` stays 0.
- Drop `lock` in RUN → `rst_n_out`=0 3 edges later, `lock_lost_cnt`=1; re-raise `lock` → full re-sequence. Force 260 losses with `CNT_W`=8 → count saturates at 255.
- `sw_rst_req` pulse in RUN, `HOLD_CYC`=16 → `rst_n_out`=0 next edge, `state`=3 for 16 cycles, then WAIT_LOCK and re-release after 8 cycles; a request during RELEASE is ignored.
- `sw_rst_req` on the same edge `lock_s` falls → `state`=0, `lock_lost_cnt` increments, HOLD never entered. Assert `reset` mid-RELEASE → all outputs return to reset values immediately.
- With `RTC_RST_SEQ_TICK_EN`, `TICK_DIV`=4 → `tick` pulses at RUN+4, +8, +12; stops on lock loss; absent and 0 without the macro.

Source files
------------

// File: rtl/rtc_rst_sequencer.sv
// rtl/rtc_rst_sequencer.sv - lock-qualified staggered reset sequencer (optional tick: RTC_RST_SEQ_TICK_EN)
module rtc_rst_sequencer #(
    parameter int NUM_CH   = 3,
    parameter int LOCK_DLY = 8,
    parameter int STAGGER  = 4,
    parameter int HOLD_CYC = 16,
    parameter int CNT_W    = 8,
    parameter int TICK_DIV = 32768
) (
    input  logic              clkout_rtc,
    input  logic              reset,
    input  logic              lock,
    input  logic              sw_rst_req,
    output logic [NUM_CH-1:0] rst_n_out,
    output logic              all_released,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  lock_lost_cnt,
    output logic              tick
);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_REL  = 2'd1,
        ST_RUN  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam int DW = $clog2(LOCK_DLY + 1);
    localparam int SW = $clog2(STAGGER + 1);
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam int RW = $clog2(NUM_CH + 1);

    localparam logic [DW-1:0] DLY_LAST  = DW'(LOCK_DLY - 1);
    localparam logic [SW-1:0] STG_LAST  = SW'(STAGGER - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [RW-1:0] REL_LAST  = RW'(NUM_CH - 1);

    state_t          cur_st;
    logic            lock_meta;
    logic            lock_s;
    logic [DW-1:0]   dly_cnt;
    logic [SW-1:0]   stg_cnt;
    logic [HW-1:0]   hold_cnt;
    logic [RW-1:0]   rel_cnt;

    assign state = cur_st;

    // Two-flop synchroniser for the asynchronous PLL lock
    always_ff @(posedge clkout_rtc or negedge reset) begin
        if (!reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= lock;
            lock_s    <= lock_meta;
        end
    end

    // Sequencer FSM: qualify lock, stagger releases, hold on request, drop all on lock loss
    always_ff @(posedge clkout_rtc or negedge reset) begin
        if (!reset) begin
            cur_st        <= ST_WAIT;
            rst_n_out     <= '0;
            all_released  <= 1'b0;
            lock_lost_cnt <= '0;
            dly_cnt       <= '0;
            stg_cnt       <= '0;
            hold_cnt      <= '0;
            rel_cnt       <= '0;
        end else if (cur_st == ST_WAIT) begin
            if (lock_s) begin
                if (dly_cnt == DLY_LAST) begin
                    dly_cnt <= '0;
                    stg_cnt <= '0;
                    rel_cnt <= RW'(1);
                    if (NUM_CH == 1) begin
                        cur_st       <= ST_RUN;
                        rst_n_out    <= '1;
                        all_released <= 1'b1;
                    end else begin
                        cur_st    <= ST_REL;
                        rst_n_out <= NUM_CH'(1);
                    end
                end else begin
                    dly_cnt <= dly_cnt + 1'b1;
                end
            end else begin
                dly_cnt <= '0;
            end
        end else if (!lock_s) begin
            // Lock loss outranks everything else outside WAIT_LOCK
            cur_st       <= ST_WAIT;
            rst_n_out    <= '0;
            all_released <= 1'b0;
            dly_cnt      <= '0;
            stg_cnt      <= '0;
            hold_cnt     <= '0;
            rel_cnt      <= '0;
            if (lock_lost_cnt != '1) begin
                lock_lost_cnt <= lock_lost_cnt + 1'b1;
            end
        end else if (cur_st == ST_REL) begin
            if (stg_cnt == STG_LAST) begin
                stg_cnt   <= '0;
                rel_cnt   <= rel_cnt + 1'b1;
                rst_n_out <= (rst_n_out << 1) | NUM_CH'(1);
                if (rel_cnt == REL_LAST) begin
                    cur_st       <= ST_RUN;
                    all_released <= 1'b1;
                end
            end else begin
                stg_cnt <= stg_cnt + 1'b1;
            end
        end else if (cur_st == ST_RUN) begin
            if (sw_rst_req) begin
                cur_st       <= ST_HOLD;
                rst_n_out    <= '0;
                all_released <= 1'b0;
                hold_cnt     <= '0;
                rel_cnt      <= '0;
            end
        end else begin
            if (hold_cnt == HOLD_LAST) begin
                cur_st   <= ST_WAIT;
                hold_cnt <= '0;
                dly_cnt  <= '0;
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

`ifdef RTC_RST_SEQ_TICK_EN
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] tick_cnt;

    // Periodic tick that only runs while every channel is released
    always_ff @(posedge clkout_rtc or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else if (cur_st == ST_RUN) begin
            if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
                tick     <= 1'b1;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
                tick     <= 1'b0;
            end
        end else begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end
    end
`else
    assign tick = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_rst_sequencer.sv
// tb/tb_rtc_rst_sequencer.sv - self-checking bench for rtc_rst_sequencer
module tb_rtc_rst_sequencer;

    localparam int NUM_CH   = 3;
    localparam int LOCK_DLY = 8;
    localparam int STAGGER  = 4;
    localparam int HOLD_CYC = 16;
    localparam int CNT_W    = 8;
    localparam int TICK_DIV = 4;
`ifdef RTC_RST_SEQ_TICK_EN
    localparam bit TICK_ON = 1'b1;
`else
    localparam bit TICK_ON = 1'b0;
`endif

    localparam int P_WAIT = 0;
    localparam int P_REL  = 1;
    localparam int P_RUN  = 2;
    localparam int P_HOLD = 3;

    logic              clkout_rtc = 1'b0;
    logic              reset      = 1'b0;
    logic              lock       = 1'b0;
    logic              sw_rst_req = 1'b0;
    logic [NUM_CH-1:0] rst_n_out;
    logic              all_released;
    logic [1:0]        state;
    logic [CNT_W-1:0]  lock_lost_cnt;
    logic              tick;

    int tests = 0;
    int fails = 0;

    rtc_rst_sequencer #(
        .NUM_CH  (NUM_CH),
        .LOCK_DLY(LOCK_DLY),
        .STAGGER (STAGGER),
        .HOLD_CYC(HOLD_CYC),
        .CNT_W   (CNT_W),
        .TICK_DIV(TICK_DIV)
    ) dut (
        .clkout_rtc   (clkout_rtc),
        .reset        (reset),
        .lock         (lock),
        .sw_rst_req   (sw_rst_req),
        .rst_n_out    (rst_n_out),
        .all_released (all_released),
        .state        (state),
        .lock_lost_cnt(lock_lost_cnt),
        .tick         (tick)
    );

    always #5 clkout_rtc = ~clkout_rtc;

    // Behavioural model: phase plus edge timestamps, outputs derived arithmetically
    int m_n = 0;
    int m_phase = P_WAIT;
    int m_streak = 0;
    int m_rel_start = 0;
    int m_run_start = 0;
    int m_hold_start = 0;
    int m_rel = 0;
    int m_cnt = 0;
    bit m_l1 = 1'b0;
    bit m_l2 = 1'b0;
    bit m_tick = 1'b0;

    function automatic logic [31:0] exp_rst();
        if (m_phase == P_REL) return (32'd1 << m_rel) - 32'd1;
        if (m_phase == P_RUN) return (32'd1 << NUM_CH) - 32'd1;
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_phase  = P_WAIT;
        m_streak = 0;
        m_rel    = 0;
        m_cnt    = 0;
        m_l1     = 1'b0;
        m_l2     = 1'b0;
        m_tick   = 1'b0;
    endtask

    task automatic model_step();
        bit ls;
        int prev;
        ls   = m_l2;
        m_l2 = m_l1;
        m_l1 = lock;
        m_n++;
        prev   = m_phase;
        m_tick = 1'b0;
        if (TICK_ON && prev == P_RUN && ((m_n - m_run_start) % TICK_DIV) == 0) m_tick = 1'b1;
        if (prev == P_WAIT) begin
            if (ls) begin
                m_streak++;
                if (m_streak == LOCK_DLY) begin
                    m_streak    = 0;
                    m_rel_start = m_n;
                    m_rel       = 1;
                    if (NUM_CH == 1) begin
                        m_phase     = P_RUN;
                        m_run_start = m_n;
                    end else begin
                        m_phase = P_REL;
                    end
                end
            end else begin
                m_streak = 0;
            end
        end else if (!ls) begin
            m_phase  = P_WAIT;
            m_streak = 0;
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end else if (prev == P_REL) begin
            m_rel = 1 + (m_n - m_rel_start) / STAGGER;
            if (m_rel >= NUM_CH) begin
                m_phase     = P_RUN;
                m_run_start = m_n;
            end
        end else if (prev == P_RUN) begin
            if (sw_rst_req) begin
                m_phase      = P_HOLD;
                m_hold_start = m_n;
            end
        end else if (m_n - m_hold_start == HOLD_CYC) begin
            m_phase  = P_WAIT;
            m_streak = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clkout_rtc);
            #1;
        end
    endtask

    // Model advances on every active edge and on asynchronous reset assertion
    initial forever begin
        @(posedge clkout_rtc or negedge reset);
        if (!reset) model_reset();
        else model_step();
    end

    // Every-cycle comparison against the model on the inactive edge
    initial forever begin
        @(negedge clkout_rtc);
        chk("cyc_rst_n_out", 32'(rst_n_out), exp_rst());
        chk("cyc_all_released", 32'(all_released), 32'(m_phase == P_RUN));
        chk("cyc_state", 32'(state), 32'(m_phase));
        chk("cyc_lock_lost_cnt", 32'(lock_lost_cnt), 32'(m_cnt));
        chk("cyc_tick", 32'(tick), 32'(m_tick));
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset values
        adv(3);
        chk("lit_reset_rst", 32'(rst_n_out), 32'd0);
        chk("lit_reset_state", 32'(state), 32'd0);
        chk("lit_reset_cnt", 32'(lock_lost_cnt), 32'd0);
        reset = 1'b1;
        adv(2);

        // Lock rise: channels release at edges 10/14/18
        lock = 1'b1;
        adv(9);
        chk("lit_e9_rst", 32'(rst_n_out), 32'd0);
        adv(1);
        chk("lit_e10_rst", 32'(rst_n_out), 32'd1);
        chk("lit_e10_state", 32'(state), 32'd1);
        adv(3);
        chk("lit_e13_rst", 32'(rst_n_out), 32'd1);
        adv(1);
        chk("lit_e14_rst", 32'(rst_n_out), 32'd3);
        adv(3);
        chk("lit_e17_all", 32'(all_released), 32'd0);
        adv(1);
        chk("lit_e18_rst", 32'(rst_n_out), 32'd7);
        chk("lit_e18_all", 32'(all_released), 32'd1);
        chk("lit_e18_state", 32'(state), 32'd2);
        adv(3);
        chk("lit_tick_run3", 32'(tick), 32'd0);
        adv(1);
        chk("lit_tick_run4", 32'(tick), 32'(TICK_ON));

        // Lock loss in RUN: resets fall three edges later
        lock = 1'b0;
        adv(2);
        chk("lit_loss_e2_rst", 32'(rst_n_out), 32'd7);
        adv(1);
        chk("lit_loss_e3_rst", 32'(rst_n_out), 32'd0);
        chk("lit_loss_e3_cnt", 32'(lock_lost_cnt), 32'd1);
        chk("lit_loss_e3_state", 32'(state), 32'd0);

        // Full re-sequence
        lock = 1'b1;
        adv(18);
        chk("lit_reseq_state", 32'(state), 32'd2);

        // Software request in RUN: HOLD for 16 edges, then re-qualify
        sw_rst_req = 1'b1;
        adv(1);
        sw_rst_req = 1'b0;
        chk("lit_sw_rst", 32'(rst_n_out), 32'd0);
        chk("lit_sw_state", 32'(state), 32'd3);
        adv(15);
        chk("lit_hold15_state", 32'(state), 32'd3);
        adv(1);
        chk("lit_hold16_state", 32'(state), 32'd0);
        adv(7);
        chk("lit_requal7_rst", 32'(rst_n_out), 32'd0);
        adv(1);
        chk("lit_requal8_rst", 32'(rst_n_out), 32'd1);

        // Request during RELEASE is ignored
        sw_rst_req = 1'b1;
        adv(2);
        sw_rst_req = 1'b0;
        chk("lit_swrel_state", 32'(state), 32'd1);
        adv(6);
        chk("lit_swrel_run", 32'(rst_n_out), 32'd7);

        // One-cycle lock glitch while qualifying restarts the delay, uncounted
        lock = 1'b0;
        adv(3);
        chk("lit_loss2_cnt", 32'(lock_lost_cnt), 32'd2);
        lock = 1'b1;
        adv(5);
        lock = 1'b0;
        adv(1);
        lock = 1'b1;
        adv(9);
        chk("lit_glitch_e15_rst", 32'(rst_n_out), 32'd0);
        adv(1);
        chk("lit_glitch_e16_rst", 32'(rst_n_out), 32'd1);
        chk("lit_glitch_cnt", 32'(lock_lost_cnt), 32'd2);
        adv(8);
        chk("lit_glitch_run", 32'(state), 32'd2);

        // Request on the edge lock loss is seen: lock loss wins
        lock = 1'b0;
        adv(2);
        chk("lit_simul_pre", 32'(state), 32'd2);
        sw_rst_req = 1'b1;
        adv(1);
        sw_rst_req = 1'b0;
        chk("lit_simul_state", 32'(state), 32'd0);
        chk("lit_simul_cnt", 32'(lock_lost_cnt), 32'd3);
        adv(3);
        chk("lit_simul_nohold", 32'(state), 32'd0);

        // 260 further losses saturate the counter
        for (int i = 0; i < 260; i++) begin
            lock = 1'b1;
            adv(11);
            lock = 1'b0;
            adv(3);
        end
        chk("lit_sat_cnt", 32'(lock_lost_cnt), 32'd255);

        // Asynchronous reset mid-RELEASE
        lock = 1'b1;
        adv(12);
        chk("lit_prerst_state", 32'(state), 32'd1);
        reset = 1'b0;
        #1;
        chk("lit_async_rst", 32'(rst_n_out), 32'd0);
        chk("lit_async_state", 32'(state), 32'd0);
        chk("lit_async_cnt", 32'(lock_lost_cnt), 32'd0);
        chk("lit_async_all", 32'(all_released), 32'd0);
        adv(2);
        reset = 1'b1;
        adv(9);
        chk("lit_postrst_e9", 32'(state), 32'd0);
        adv(1);
        chk("lit_postrst_e10", 32'(state), 32'd1);
        adv(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
